// File: rtl/cdc_xfer_pkg.sv
// Shared types and defaults for the CDC transfer scheduler: FSM state encoding,
// parameter defaults and the round-robin index width helper.
package cdc_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GUARD   = 3'd4
    } state_e;

    localparam int NREQ_DEF     = 4;
    localparam int DW_DEF       = 4;
    localparam int HOLD_CYC_DEF = 6;
    localparam int TO_CYC_DEF   = 64;

    // Width of an index into NREQ requesters, never below one bit.
    function automatic int rr_idx_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop level synchronizer into clk_a; both stages reset to 0.
module cdc_sync_2ff (
    input  logic clk_a,
    input  logic arstn,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/cdc_xfer_sched.sv
// Round-robin scheduler sharing one data/enable CDC channel between NREQ requesters,
// with a four-phase en/ack handshake and guard gap. CDC_XFER_SCHED_TIMEOUT_EN adds an ack-rise timeout.
module cdc_xfer_sched
    import cdc_xfer_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DW       = DW_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int TO_CYC   = TO_CYC_DEF
) (
    input  logic               clk_a,
    input  logic               arstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      xfer_data,
    output logic               xfer_en,
    input  logic               xfer_ack_async,
    output logic               busy,
    output logic               err_timeout
);

    localparam int IW = rr_idx_w(NREQ);
    localparam int GW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [IW-1:0] LAST_RST   = IW'(NREQ - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [DW-1:0]     data_q, data_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic              ack_s;
    logic              rr_found;
    logic [IW-1:0]     rr_win;
    logic [DW-1:0]     word [NREQ];

    cdc_sync_2ff u_ack_sync (
        .clk_a   (clk_a),
        .arstn   (arstn),
        .async_i (xfer_ack_async),
        .sync_o  (ack_s)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign word[gi] = req_data[gi*DW +: DW];
    end

    // First requester at or after last+1, wrapping; the previous winner is searched last.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!rr_found && req[(int'(last_q) + 1 + k) % NREQ]) begin
                rr_found = 1'b1;
                rr_win   = IW'((int'(last_q) + 1 + k) % NREQ);
            end
        end
    end

`ifdef CDC_XFER_SCHED_TIMEOUT_EN
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;
    logic          to_hit;
    assign to_hit = (to_cnt_q == TW'(TO_CYC - 1));
`endif

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            last_q   <= LAST_RST;
            data_q   <= '0;
            gnt_q    <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            guard_q  <= '0;
`ifdef CDC_XFER_SCHED_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            guard_q  <= guard_d;
`ifdef CDC_XFER_SCHED_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rr_found) state_d = SETUP;
            SETUP:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (ack_s) state_d = WAIT_LO;
`ifdef CDC_XFER_SCHED_TIMEOUT_EN
                else if (to_hit) state_d = WAIT_LO;
`endif
            end
            WAIT_LO: if (!ack_s) state_d = GUARD;
            GUARD:   if (guard_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered off state_d so they line up with the state they belong to.
    always_comb begin
        last_d  = last_q;
        data_d  = data_q;
        gnt_d   = '0;
        guard_d = guard_q;
        en_d    = (state_d == WAIT_HI);
        busy_d  = (state_d != IDLE);
        if (state_q == IDLE && rr_found) begin
            last_d         = rr_win;
            data_d         = word[rr_win];
            gnt_d[rr_win]  = 1'b1;
        end
        if (state_q == WAIT_LO) begin
            guard_d = GUARD_LOAD;
        end else if (state_q == GUARD && guard_q != '0) begin
            guard_d = guard_q - GW'(1);
        end
`ifdef CDC_XFER_SCHED_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = 1'b0;
        if (state_q == SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == WAIT_HI && !ack_s) begin
            if (to_hit) err_d = 1'b1;
            else        to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
    end

    assign gnt       = gnt_q;
    assign xfer_data = data_q;
    assign xfer_en   = en_q;
    assign busy      = busy_q;

`ifdef CDC_XFER_SCHED_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    logic unused_to_cfg;
    assign unused_to_cfg = (TO_CYC > 0);
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: doc/cdc_xfer_sched.md
Name: cdc_xfer_sched

Overview:
- Source-domain scheduler that shares one 4-bit data/enable CDC channel between NREQ requesters.
- Round-robin arbitrates the requesters and holds the winner's word stable on xfer_data.
- Sequences a four-phase en/ack handshake with the destination domain and enforces a guard gap before the next launch.
- Sits in clk_a, ahead of the channel's data/enable capture registers; the returning ack is synchronized inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data width per requester.
- HOLD_CYC, 6, guard cycles after ack falls; xfer_data stays stable during them (>=1).
- TO_CYC, 64, ack-rise timeout in cycles; used only with the optional feature.

Ports:
- clk_a  in  1  source-domain clock.
- arstn  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  NREQ  per-requester level request; must be held until granted.
- req_data  in  NREQ*DW  requester words; slice i = req_data[i*DW +: DW].
- gnt  out  NREQ  one-hot, one-cycle pulse: requester's word was captured.
- xfer_data  out  DW  captured word, registered, toward the CDC channel.
- xfer_en  out  1  handshake request level toward the destination domain.
- xfer_ack_async  in  1  ack level from the destination domain, asynchronous to clk_a.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on ack timeout; constant 0 without the macro.

Behaviour:
- Reset values: gnt=0, xfer_data=0, xfer_en=0, busy=0, err_timeout=0, FSM=IDLE, rr pointer last=NREQ-1, both ack sync flops=0.
- Reset asserted mid-transfer clears everything immediately (async). The destination sees xfer_en drop; no transfer is replayed.
- ack_s is xfer_ack_async passed through a 2-flop synchronizer, so 2 cycles of latency.
- IDLE: if req!=0, pick the first set bit searching from (last+1) mod NREQ upward with wrap. Next edge: capture that requester's slice into xfer_data, pulse gnt[w], set last=w, go to SETUP. If req==0, stay in IDLE.
- SETUP: one cycle with data valid and xfer_en=0 (setup before enable). Next edge sets xfer_en=1 and goes to WAIT_HI.
- WAIT_HI: xfer_en=1 until ack_s==1. Then xfer_en=0 and go to WAIT_LO.
- WAIT_LO: xfer_en=0 until ack_s==0. Then go to GUARD with guard counter=HOLD_CYC-1.
- GUARD: decrement each cycle; at 0 go to IDLE. xfer_data is unchanged from capture until IDLE re-arbitrates.
- Minimum launch-to-launch spacing is 1 (IDLE) + 1 (SETUP) + (WAIT_HI dwell >= 1) + (WAIT_LO dwell >= 1) + HOLD_CYC cycles; the two dwells grow with the ack round trip.
- ack_s already high on entry to WAIT_HI (stale ack): no special case; the handshake completes normally.
- Requests arriving outside IDLE wait; dropping req before its grant is allowed and that requester simply loses its turn.
- gnt is never asserted outside the IDLE->SETUP edge. At most one gnt bit is set.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: CDC_XFER_SCHED_TIMEOUT_EN.
- With the macro: a counter runs in WAIT_HI. If ack_s is still 0 after TO_CYC cycles, pulse err_timeout for 1 cycle, drop xfer_en and go to WAIT_LO (the normal return path, no timeout there). The counter clears on entry to WAIT_HI.
- Without the macro: no counter, err_timeout tied to 0, and WAIT_HI waits indefinitely.

Decomposition:
- Shared package cdc_xfer_pkg: state enum (IDLE, SETUP, WAIT_HI, WAIT_LO, GUARD), default parameter constants, and a function computing the round-robin index width, clog2(NREQ).
- One sub-module, cdc_sync_2ff: 2-flop level synchronizer, clk_a/arstn, reset value 0, used for xfer_ack_async.

Test Plan:
- Single request: req=4'b0001, req_data[3:0]=4'hA, ack returned 3 cycles after xfer_en rises -> gnt[0] pulse; xfer_data=4'hA one cycle before xfer_en=1; xfer_en falls 2 cycles after ack rises; busy low after HOLD_CYC=6 guard cycles.
- All four requesting continuously with words 1,2,3,4 -> grants in order 0,1,2,3,0; xfer_data sequence 1,2,3,4,1; never two gnt bits in one cycle.
- Stale ack: xfer_ack_async held 1 on entry to WAIT_HI -> xfer_en is high for exactly the 1 cycle of the synchronized ack, then waits for ack low; no gnt until GUARD ends.
- Reset pulse during WAIT_HI -> xfer_en, gnt, xfer_data, busy read 0 immediately; after release req0 wins first (last=NREQ-1).
- With CDC_XFER_SCHED_TIMEOUT_EN and TO_CYC=64, ack never asserted -> err_timeout pulses once after 64 cycles in WAIT_HI; xfer_en=0; FSM returns to IDLE after HOLD_CYC; next requester granted.
- Without the macro, same stimulus -> xfer_en stays 1 and err_timeout stays 0 for 200 cycles.
